rr_arbiter: RTL and testbench

N-requester round-robin arbiter with burst-length limit. It grants one shared resource to one agent at a time and holds the grant while that agent keeps requesting. It forces a release after MAX_HOLD cycles if another agent is waiting. It sits in front of any shared datapath resource and generalises the two-agent fixed-priority arbiter to N agents with fairness and starvation protection.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 31 +++
 rtl/rr_arbiter.sv | 95 +++++++++
 tb/tb_rr_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared state encoding and circular index arithmetic for the round-robin arbiter.
package arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // (a + b) mod n for operands already in 0..n-1, without a divider.
   function automatic int circ_add(input int a, input int b, input int n);
      int s;
      s = a + b;
      return (s >= n) ? s - n : s;
   endfunction

   function automatic int next_idx(input int i, input int n);
      return circ_add(i, 1, n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping at N.
module rr_pick
   import arb_pkg::*;
#(
   parameter  int N    = 4,
   localparam int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic            pick_valid,
   output logic [ID_W-1:0] pick_id
);

   logic [N-1:0] w_rot;
   int           w_enc;

   // Rotate so ptr lands at bit 0, take the lowest set bit, then map back.
   always_comb begin
      w_rot = '0;
      for (int j = 0; j < N; j++) begin
         w_rot[j] = req[circ_add(j, int'(ptr), N)];
      end
      w_enc = 0;
      for (int j = N - 1; j >= 0; j--) begin
         if (w_rot[j]) w_enc = j;
      end
      pick_valid = |req;
      pick_id    = ID_W'(circ_add(w_enc, int'(ptr), N));
   end

endmodule

// File: rtl/rr_arbiter.sv
// N-requester round-robin arbiter with a hold limit that only bites under contention.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter  int N        = 4,
   parameter  int MAX_HOLD = 16,
   localparam int ID_W     = $clog2(N)
) (
   input  logic            clk,
   input  logic            rest,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    gnt,
   output logic            gnt_valid,
   output logic [ID_W-1:0] gnt_id,
   output logic            timeout,
   output logic            dbg_state
);

   localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] CNT_SAT = (MAX_HOLD == 0) ? CNT_W'(1) : CNT_W'(MAX_HOLD);

   state_t            r_state;
   logic [ID_W-1:0]   r_owner;
   logic [ID_W-1:0]   r_ptr;
   logic [CNT_W-1:0]  r_cnt;
   logic [N-1:0]      r_gnt;
   logic              r_gnt_valid;
   logic [ID_W-1:0]   r_gnt_id;
   logic              r_timeout;

   logic              w_pick_valid;
   logic [ID_W-1:0]   w_pick_id;
   logic [N-1:0]      w_pick_oh;
   logic [N-1:0]      w_owner_oh;
   logic              w_force;

   rr_pick #(.N(N)) u_pick (
      .req        (req),
      .ptr        (r_ptr),
      .pick_valid (w_pick_valid),
      .pick_id    (w_pick_id)
   );

   assign w_pick_oh  = {{(N-1){1'b0}}, 1'b1} << w_pick_id;
   assign w_owner_oh = {{(N-1){1'b0}}, 1'b1} << r_owner;
   assign w_force    = (MAX_HOLD != 0) && (r_cnt == CNT_W'(MAX_HOLD)) && (|(req & ~w_owner_oh));

   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         r_state     <= ST_IDLE;
         r_owner     <= '0;
         r_ptr       <= '0;
         r_cnt       <= '0;
         r_gnt       <= '0;
         r_gnt_valid <= 1'b0;
         r_gnt_id    <= '0;
         r_timeout   <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pick_valid) begin
                  r_state     <= ST_GRANT;
                  r_owner     <= w_pick_id;
                  r_cnt       <= CNT_W'(1);
                  r_gnt       <= w_pick_oh;
                  r_gnt_valid <= 1'b1;
                  r_gnt_id    <= w_pick_id;
               end
            end
            ST_GRANT: begin
               // Owner dropping its request takes precedence over a forced release.
               if (!req[r_owner] || w_force) begin
                  r_state     <= ST_IDLE;
                  r_ptr       <= ID_W'(next_idx(int'(r_owner), N));
                  r_gnt       <= '0;
                  r_gnt_valid <= 1'b0;
                  r_gnt_id    <= '0;
                  r_timeout   <= req[r_owner];
               end else if (r_cnt != CNT_SAT) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign gnt_valid = r_gnt_valid;
   assign gnt_id    = r_gnt_id;
   assign timeout   = r_timeout;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N=4/MAX_HOLD=4 and N=3/MAX_HOLD=0) and rr_pick (N=3, N=4).
module tb_rr_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Instance A: N=4, MAX_HOLD=4
   logic       rst_a;
   logic [3:0] req_a;
   logic [3:0] gnt_a;
   logic       gv_a;
   logic [1:0] gid_a;
   logic       to_a;
   logic       st_a;
   logic [8:0] obs_a;
   assign obs_a = {gnt_a, gv_a, gid_a, to_a, st_a};

   rr_arbiter #(.N(4), .MAX_HOLD(4)) dut_a (
      .clk(clk), .rest(rst_a), .req(req_a), .gnt(gnt_a), .gnt_valid(gv_a),
      .gnt_id(gid_a), .timeout(to_a), .dbg_state(st_a)
   );

   // Instance B: N=3, hold limit disabled
   logic       rst_b;
   logic [2:0] req_b;
   logic [2:0] gnt_b;
   logic       gv_b;
   logic [1:0] gid_b;
   logic       to_b;
   logic       st_b;
   logic [7:0] obs_b;
   assign obs_b = {gnt_b, gv_b, gid_b, to_b, st_b};

   rr_arbiter #(.N(3), .MAX_HOLD(0)) dut_b (
      .clk(clk), .rest(rst_b), .req(req_b), .gnt(gnt_b), .gnt_valid(gv_b),
      .gnt_id(gid_b), .timeout(to_b), .dbg_state(st_b)
   );

   // Standalone pickers
   logic [2:0] p3_req;
   logic [1:0] p3_ptr;
   logic       p3_v;
   logic [1:0] p3_id;
   logic [3:0] p4_req;
   logic [1:0] p4_ptr;
   logic       p4_v;
   logic [1:0] p4_id;

   rr_pick #(.N(3)) pick3 (.req(p3_req), .ptr(p3_ptr), .pick_valid(p3_v), .pick_id(p3_id));
   rr_pick #(.N(4)) pick4 (.req(p4_req), .ptr(p4_ptr), .pick_valid(p4_v), .pick_id(p4_id));

   // Expected {gnt, gnt_valid, gnt_id, timeout, state} for instance A; agent<0 means no grant.
   function automatic logic [8:0] exp_a(input int agent, input logic to);
      logic [3:0] oh;
      logic       v;
      logic [1:0] id;
      oh = 4'b0000;
      v  = 1'b0;
      id = 2'd0;
      if (agent >= 0) begin
         oh[agent] = 1'b1;
         v         = 1'b1;
         id        = 2'(agent);
      end
      return {oh, v, id, to, v};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; req_a = 4'b0000;
      rst_b = 1'b1; req_b = 3'b000;
      tick(); tick();
      n_checks++;
      if (obs_a !== exp_a(-1, 1'b0)) begin
         n_fail++; $display("FAIL reset_initial: got %b want %b", obs_a, exp_a(-1, 1'b0));
      end
      rst_a = 1'b0; rst_b = 1'b0;
      req_a = 4'b1111;
      tick();
      n_checks++;
      if (obs_a !== exp_a(0, 1'b0)) begin
         n_fail++; $display("FAIL reset_pre_grant: got %b want %b", obs_a, exp_a(0, 1'b0));
      end
      #2 rst_a = 1'b1;
      #1;
      n_checks++;
      if (obs_a !== exp_a(-1, 1'b0)) begin
         n_fail++; $display("FAIL reset_async_clear: got %b want %b", obs_a, exp_a(-1, 1'b0));
      end
      tick();
      req_a = 4'b0000;
      rst_a = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if (obs_a !== exp_a(-1, 1'b0)) begin
            n_fail++; $display("FAIL reset_idle_after[%0d]: got %b want %b", k, obs_a, exp_a(-1, 1'b0));
         end
      end
   endtask

   task automatic test_single();
      req_a = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if (obs_a !== exp_a(2, 1'b0)) begin
            n_fail++; $display("FAIL single_hold[%0d]: got %b want %b", k, obs_a, exp_a(2, 1'b0));
         end
      end
      req_a = 4'b0000;
      tick();
      n_checks++;
      if (obs_a !== exp_a(-1, 1'b0)) begin
         n_fail++; $display("FAIL single_release: got %b want %b", obs_a, exp_a(-1, 1'b0));
      end
      req_a = 4'b0001;
      tick();
      n_checks++;
      if (obs_a !== exp_a(0, 1'b0)) begin
         n_fail++; $display("FAIL single_wrap_grant0: got %b want %b", obs_a, exp_a(0, 1'b0));
      end
      req_a = 4'b0000;
      tick();
      n_checks++;
      if (obs_a !== exp_a(-1, 1'b0)) begin
         n_fail++; $display("FAIL single_wrap_release: got %b want %b", obs_a, exp_a(-1, 1'b0));
      end
   endtask

   task automatic test_fairness();
      int a;
      rst_a = 1'b1; #2 rst_a = 1'b0;
      req_a = 4'b1111;
      for (int g = 0; g < 8; g++) begin
         a = g % 4;
         for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (obs_a !== exp_a(a, 1'b0)) begin
               n_fail++; $display("FAIL fair_grant[%0d.%0d]: got %b want %b", g, c, obs_a, exp_a(a, 1'b0));
            end
         end
         req_a[a] = 1'b0;
         tick();
         n_checks++;
         if (obs_a !== exp_a(-1, 1'b0)) begin
            n_fail++; $display("FAIL fair_gap[%0d]: got %b want %b", g, obs_a, exp_a(-1, 1'b0));
         end
         req_a[a] = 1'b1;
      end
      req_a = 4'b0000;
      tick();
   endtask

   task automatic test_timeout();
      int a;
      req_a = 4'b1010;
      for (int r = 0; r < 4; r++) begin
         a = (r % 2 == 0) ? 1 : 3;
         for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (obs_a !== exp_a(a, 1'b0)) begin
               n_fail++; $display("FAIL timeout_hold[%0d.%0d]: got %b want %b", r, c, obs_a, exp_a(a, 1'b0));
            end
         end
         tick();
         n_checks++;
         if (obs_a !== exp_a(-1, 1'b1)) begin
            n_fail++; $display("FAIL timeout_pulse[%0d]: got %b want %b", r, obs_a, exp_a(-1, 1'b1));
         end
      end
      req_a = 4'b0000;
      tick();
      n_checks++;
      if (obs_a !== exp_a(-1, 1'b0)) begin
         n_fail++; $display("FAIL timeout_pulse_width: got %b want %b", obs_a, exp_a(-1, 1'b0));
      end
   endtask

   task automatic test_solo_hog();
      req_a = 4'b0001;
      for (int c = 0; c < 20; c++) begin
         tick();
         n_checks++;
         if (obs_a !== exp_a(0, 1'b0)) begin
            n_fail++; $display("FAIL solo_hold[%0d]: got %b want %b", c, obs_a, exp_a(0, 1'b0));
         end
      end
      req_a = 4'b0000;
      tick();
      n_checks++;
      if (obs_a !== exp_a(-1, 1'b0)) begin
         n_fail++; $display("FAIL solo_release: got %b want %b", obs_a, exp_a(-1, 1'b0));
      end
   endtask

   task automatic test_boundary();
      req_a = 4'b0110;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_checks++;
         if (obs_a !== exp_a(1, 1'b0)) begin
            n_fail++; $display("FAIL bound_hold[%0d]: got %b want %b", c, obs_a, exp_a(1, 1'b0));
         end
      end
      req_a = 4'b0100;
      tick();
      n_checks++;
      if (obs_a !== exp_a(-1, 1'b0)) begin
         n_fail++; $display("FAIL bound_release_no_timeout: got %b want %b", obs_a, exp_a(-1, 1'b0));
      end
      tick();
      n_checks++;
      if (obs_a !== exp_a(2, 1'b0)) begin
         n_fail++; $display("FAIL bound_next_grant: got %b want %b", obs_a, exp_a(2, 1'b0));
      end
      req_a = 4'b0000;
      tick();
   endtask

   task automatic test_reset_mid_grant();
      req_a = 4'b0100;
      tick();
      n_checks++;
      if (obs_a !== exp_a(2, 1'b0)) begin
         n_fail++; $display("FAIL midrst_owner2: got %b want %b", obs_a, exp_a(2, 1'b0));
      end
      req_a = 4'b1111;
      tick();
      n_checks++;
      if (obs_a !== exp_a(2, 1'b0)) begin
         n_fail++; $display("FAIL midrst_keep: got %b want %b", obs_a, exp_a(2, 1'b0));
      end
      #2 rst_a = 1'b1;
      #1;
      n_checks++;
      if (obs_a !== exp_a(-1, 1'b0)) begin
         n_fail++; $display("FAIL midrst_clear: got %b want %b", obs_a, exp_a(-1, 1'b0));
      end
      tick();
      rst_a = 1'b0;
      tick();
      n_checks++;
      if (obs_a !== exp_a(0, 1'b0)) begin
         n_fail++; $display("FAIL midrst_restart_agent0: got %b want %b", obs_a, exp_a(0, 1'b0));
      end
      req_a = 4'b0000;
      tick();
   endtask

   task automatic test_no_limit();
      req_b = 3'b011;
      for (int c = 0; c < 25; c++) begin
         tick();
         n_checks++;
         if (obs_b !== 8'b001_1_00_0_1) begin
            n_fail++; $display("FAIL nolimit_hold[%0d]: got %b want %b", c, obs_b, 8'b001_1_00_0_1);
         end
      end
      req_b = 3'b000;
      tick();
      n_checks++;
      if (obs_b !== 8'b000_0_00_0_0) begin
         n_fail++; $display("FAIL nolimit_release: got %b want %b", obs_b, 8'b000_0_00_0_0);
      end
   endtask

   task automatic test_pick();
      logic       ev;
      logic [1:0] eid;
      int         idx;
      for (int p = 0; p < 3; p++) begin
         for (int r = 0; r < 8; r++) begin
            p3_ptr = 2'(p); p3_req = 3'(r);
            #1;
            ev = 1'b0; eid = 2'd0;
            for (int k = 0; k < 3; k++) begin
               idx = (p + k) % 3;
               if (!ev && p3_req[idx]) begin ev = 1'b1; eid = 2'(idx); end
            end
            n_checks++;
            if ({p3_v, (ev ? p3_id : 2'd0)} !== {ev, eid}) begin
               n_fail++; $display("FAIL pick3 ptr=%0d req=%b: got v=%b id=%0d want v=%b id=%0d", p, p3_req, p3_v, p3_id, ev, eid);
            end
         end
      end
      for (int p = 0; p < 4; p++) begin
         for (int r = 0; r < 16; r++) begin
            p4_ptr = 2'(p); p4_req = 4'(r);
            #1;
            ev = 1'b0; eid = 2'd0;
            for (int k = 0; k < 4; k++) begin
               idx = (p + k) % 4;
               if (!ev && p4_req[idx]) begin ev = 1'b1; eid = 2'(idx); end
            end
            n_checks++;
            if ({p4_v, (ev ? p4_id : 2'd0)} !== {ev, eid}) begin
               n_fail++; $display("FAIL pick4 ptr=%0d req=%b: got v=%b id=%0d want v=%b id=%0d", p, p4_req, p4_v, p4_id, ev, eid);
            end
         end
      end
   endtask

   initial begin
      p3_req = '0; p3_ptr = '0; p4_req = '0; p4_ptr = '0;
      test_reset();
      test_single();
      test_fairness();
      test_timeout();
      test_solo_hog();
      test_boundary();
      test_reset_mid_grant();
      test_no_limit();
      test_pick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
